uart_tx_scheduler: RTL and testbench

Shares one serial transmit line between NUM_REQ byte producers using round-robin arbitration. It also sequences the transmit frame: start bit, DATA_BITS data bits sent LSB first, then one stop bit, with every bit held for CLKS_PER_BIT clocks. The frame format matches the team's uart_rx, so this block is the transmit-side counterpart on the same serial link.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 40 ++++
 rtl/uart_tx_scheduler.sv | 107 ++++++++++
 tb/tb_uart_tx_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and round-robin selection helper for the UART transmit scheduler
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

   localparam int MAX_REQ = 16;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } rr_pick_t;

   // First valid index searching ptr, ptr+1, ... modulo n; ptr must be below n.
   // The loop runs downwards so the lowest distance from ptr is assigned last and wins.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input logic [3:0] ptr,
                                        input int n);
      rr_pick_t r;
      int j;
      r = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < n) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (valid[j[3:0]]) begin
               r.found = 1'b1;
               r.idx   = j[3:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pointer and one-hot grant for the transmit line
module rr_arbiter import uart_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_en,
   input  logic [NUM_REQ-1:0] i_valid,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IW-1:0]      o_idx,
   output logic               o_found
);

   logic [IW-1:0]      r_ptr;
   logic [MAX_REQ-1:0] w_valid;
   logic [3:0]         w_ptr;
   rr_pick_t           w_pick;

   // widen requests and pointer to the helper's fixed width, then pick
   always_comb begin
      w_valid              = '0;
      w_valid[NUM_REQ-1:0] = i_valid;
      w_ptr                = '0;
      w_ptr[IW-1:0]        = r_ptr;
      w_pick               = rr_pick(w_valid, w_ptr, NUM_REQ);
   end

   assign o_found = w_pick.found;
   assign o_idx   = w_pick.idx[IW-1:0];
   assign o_grant = (i_en && w_pick.found) ? (NUM_REQ'(1) << w_pick.idx) : '0;

   // pointer moves just past the winner on every grant; with one requester it stays at 0
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         r_ptr <= '0;
      else if (i_en && w_pick.found)
         r_ptr <= (o_idx == IW'(NUM_REQ - 1)) ? '0 : o_idx + IW'(1);

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin shared UART transmitter (start, LSB-first data, stop)
module uart_tx_scheduler import uart_pkg::*; #(
   parameter int  NUM_REQ      = 4,
   parameter int  CLKS_PER_BIT = 16,
   parameter int  DATA_BITS    = 7,
   localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         serial_tx,
   output logic                         busy,
   output logic [GW-1:0]                grant_id
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   tx_state_e            r_state;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_tx;
   logic                 r_busy;
   logic [GW-1:0]        r_gid;
   logic                 w_en;
   logic                 w_found;
   logic                 w_wrap;
   logic [GW-1:0]        w_idx;
   logic [DATA_BITS-1:0] w_data;

   // grants are only offered while idle and never while reset is held
   assign w_en   = (r_state == IDLE) && rst_n;
   assign w_wrap = r_cnt == CW'(CLKS_PER_BIT - 1);
   assign w_data = req_data[w_idx*DATA_BITS +: DATA_BITS];

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(GW)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_en),
      .i_valid (req_valid),
      .o_grant (req_ready),
      .o_idx   (w_idx),
      .o_found (w_found)
   );

   // frame sequencer: the line level is registered and the shift register drains LSB first
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_gid   <= '0;
      end else begin
         case (r_state)
            IDLE:
               if (w_found) begin
                  r_state <= START;
                  r_cnt   <= '0;
                  r_shift <= w_data;
                  r_gid   <= w_idx;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
               end
            START: begin
               r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
               if (w_wrap) begin
                  r_state <= DATA;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
               end
            end
            DATA: begin
               r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
               if (w_wrap) begin
                  if (r_bit == BW'(DATA_BITS - 1)) begin
                     r_state <= STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit   <= r_bit + BW'(1);
                     r_tx    <= r_shift[0];
                     r_shift <= r_shift >> 1;
                  end
               end
            end
            STOP: begin
               r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
               if (w_wrap) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end

   assign serial_tx = r_tx;
   assign busy      = r_busy;
   assign grant_id  = r_gid;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized self-checking bench against a frame-level reference model
module tb_uart_tx_scheduler;

   localparam int NR  = 4;
   localparam int CPB = 16;
   localparam int DB  = 7;
   localparam int FL  = (DB + 2) * CPB;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*DB-1:0] req_data = '0;
   logic [NR-1:0]    req_ready;
   logic             serial_tx;
   logic             busy;
   logic [1:0]       grant_id;

   int n_cmp = 0;
   int n_bad = 0;

   int   m_rem = 0;
   int   m_ptr = 0;
   int   m_gid = 0;
   int   m_sel = 0;
   bit   m_hs;
   logic m_bits [0:DB+1];

   logic          e_tx;
   logic          e_busy;
   logic [NR-1:0] e_ready;
   logic [1:0]    e_gid;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .serial_tx (serial_tx),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   // One clock: drive inputs at the falling edge, record what the frame model expects for this
   // cycle, then advance the model across the coming rising edge.
   task automatic step(input logic [NR-1:0] v, input logic [NR*DB-1:0] d);
      @(negedge clk);
      req_valid = v;
      req_data  = d;
      e_tx    = (m_rem == 0) ? 1'b1 : m_bits[(FL - m_rem) / CPB];
      e_busy  = (m_rem != 0);
      e_gid   = 2'(m_gid);
      e_ready = '0;
      m_hs    = 0;
      if (m_rem == 0) begin
         for (int k = 0; k < NR; k++)
            if (!m_hs && v[(m_ptr + k) % NR]) begin
               m_hs  = 1;
               m_sel = (m_ptr + k) % NR;
            end
         if (m_hs) begin
            e_ready[m_sel] = 1'b1;
            m_bits[0] = 1'b0;
            for (int b = 0; b < DB; b++) m_bits[b+1] = d[m_sel*DB + b];
            m_bits[DB+1] = 1'b1;
            m_rem = FL;
            m_ptr = (m_sel + 1) % NR;
            m_gid = m_sel;
         end
      end else
         m_rem--;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_rem = 0;
      m_ptr = 0;
      m_gid = 0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b1;
      req_valid = 4'b1111;
      #1 rst_n = 1'b0;
      #2;
      n_cmp++;
      if ({serial_tx, busy, req_ready, grant_id} !== {1'b1, 1'b0, 4'b0000, 2'd0}) begin
         n_bad++;
         $display("FAIL reset_values got tx/busy/ready/gid=%b/%b/%b/%0d exp 1/0/0000/0",
                  serial_tx, busy, req_ready, grant_id);
      end
      repeat (2) @(negedge clk);
      req_valid = '0;
      rst_n = 1'b1;
      m_rem = 0;
      m_ptr = 0;
      m_gid = 0;
      for (int c = 0; c < 3; c++) begin
         step('0, '0);
         n_cmp++;
         if ({serial_tx, busy, req_ready, grant_id} !== {e_tx, e_busy, e_ready, e_gid}) begin
            n_bad++;
            $display("FAIL reset_idle c=%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", c, serial_tx, busy,
                     req_ready, grant_id, e_tx, e_busy, e_ready, e_gid);
         end
      end
   endtask

   task automatic test_single();
      int n_rdy = 0;
      int n_busy = 0;
      logic [DB+1:0] obs = '0;
      logic [NR*DB-1:0] d = '0;
      d[DB-1:0] = 7'h55;
      do_reset();
      for (int c = 0; c < FL + 4; c++) begin
         step(c == 0 ? 4'b0001 : 4'b0000, d);
         if (req_ready !== 4'b0000) n_rdy++;
         if (busy === 1'b1) n_busy++;
         if (c >= 1 && c <= FL && (c - 1) % CPB == CPB / 2) obs[(c - 1) / CPB] = serial_tx;
         n_cmp++;
         if ({serial_tx, busy, req_ready, grant_id} !== {e_tx, e_busy, e_ready, e_gid}) begin
            n_bad++;
            $display("FAIL single c=%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", c, serial_tx, busy,
                     req_ready, grant_id, e_tx, e_busy, e_ready, e_gid);
         end
      end
      n_cmp++;
      if (obs !== {1'b1, 7'h55, 1'b0}) begin
         n_bad++;
         $display("FAIL single_bits got %b exp %b", obs, {1'b1, 7'h55, 1'b0});
      end
      n_cmp++;
      if (n_rdy != 1) begin
         n_bad++;
         $display("FAIL single_ready_cycles got %0d exp 1", n_rdy);
      end
      n_cmp++;
      if (n_busy != FL) begin
         n_bad++;
         $display("FAIL single_busy_cycles got %0d exp %0d", n_busy, FL);
      end
   endtask

   task automatic test_round_robin();
      logic [NR*DB-1:0] d;
      logic [6:0] base;
      int order [5];
      int hs_at [5];
      int n_hs = 0;
      int exp_order [5] = '{0, 1, 2, 3, 0};
      base = 7'($urandom);
      for (int i = 0; i < NR; i++) d[i*DB +: DB] = base + 7'(29 * i);
      do_reset();
      for (int c = 0; c < 5 * (FL + 1) + 10 && n_hs < 5; c++) begin
         step(4'b1111, d);
         for (int i = 0; i < NR; i++)
            if (req_ready[i] === 1'b1) begin
               order[n_hs] = i;
               hs_at[n_hs] = c;
               n_hs++;
            end
         n_cmp++;
         if ({serial_tx, busy, req_ready, grant_id} !== {e_tx, e_busy, e_ready, e_gid}) begin
            n_bad++;
            $display("FAIL rr c=%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", c, serial_tx, busy,
                     req_ready, grant_id, e_tx, e_busy, e_ready, e_gid);
         end
      end
      n_cmp++;
      if (n_hs != 5) begin
         n_bad++;
         $display("FAIL rr_handshakes got %0d exp 5", n_hs);
      end else
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (order[i] != exp_order[i]) begin
               n_bad++;
               $display("FAIL rr_order[%0d] got %0d exp %0d", i, order[i], exp_order[i]);
            end
            if (i > 0) begin
               n_cmp++;
               if (hs_at[i] - hs_at[i-1] != FL + 1) begin
                  n_bad++;
                  $display("FAIL rr_gap[%0d] got %0d exp %0d", i, hs_at[i] - hs_at[i-1], FL + 1);
               end
            end
         end
   endtask

   task automatic test_wrap();
      logic [NR*DB-1:0] d;
      do_reset();
      for (int c = 0; c < FL + 3; c++) begin
         d = 28'($urandom);
         step(c == 0 ? 4'b0010 : (c == FL + 1 ? 4'b0011 : 4'b0000), d);
         if (c == FL + 1) begin
            n_cmp++;
            if (req_ready !== 4'b0001) begin
               n_bad++;
               $display("FAIL wrap_grant got %b exp 0001", req_ready);
            end
         end
         n_cmp++;
         if ({serial_tx, busy, req_ready, grant_id} !== {e_tx, e_busy, e_ready, e_gid}) begin
            n_bad++;
            $display("FAIL wrap c=%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", c, serial_tx, busy,
                     req_ready, grant_id, e_tx, e_busy, e_ready, e_gid);
         end
      end
   endtask

   task automatic test_data_change();
      int n_low = 0;
      do_reset();
      for (int c = 0; c < FL + 2; c++) begin
         step(c == 0 ? 4'b0001 : 4'b0000, c == 0 ? 28'h0 : 28'h000007F);
         if (c >= 1 && c <= FL && serial_tx === 1'b0) n_low++;
         n_cmp++;
         if ({serial_tx, busy, req_ready, grant_id} !== {e_tx, e_busy, e_ready, e_gid}) begin
            n_bad++;
            $display("FAIL data_change c=%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", c, serial_tx,
                     busy, req_ready, grant_id, e_tx, e_busy, e_ready, e_gid);
         end
      end
      n_cmp++;
      if (n_low != (DB + 1) * CPB) begin
         n_bad++;
         $display("FAIL data_change_low_cycles got %0d exp %0d", n_low, (DB + 1) * CPB);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [NR*DB-1:0] d;
      int run = 0;
      bit in_run = 1;
      do_reset();
      for (int c = 0; c <= CPB + 3 * CPB + 5; c++) step(c == 0 ? 4'b0001 : 4'b0000, '0);
      n_cmp++;
      if (serial_tx !== 1'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midreset_pre got tx/busy=%b/%b exp 0/1", serial_tx, busy);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({serial_tx, busy, req_ready} !== {1'b1, 1'b0, 4'b0000}) begin
         n_bad++;
         $display("FAIL midreset_async got tx/busy/ready=%b/%b/%b exp 1/0/0000", serial_tx, busy,
                  req_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_rem = 0;
      m_ptr = 0;
      m_gid = 0;
      d = 28'($urandom);
      d[2*DB] = 1'b1;
      for (int c = 0; c < FL + 2; c++) begin
         step(c == 0 ? 4'b0100 : 4'b0000, d);
         if (c >= 1 && in_run) begin
            if (serial_tx === 1'b0) run++;
            else in_run = 0;
         end
         n_cmp++;
         if ({serial_tx, busy, req_ready, grant_id} !== {e_tx, e_busy, e_ready, e_gid}) begin
            n_bad++;
            $display("FAIL midreset_after c=%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", c, serial_tx,
                     busy, req_ready, grant_id, e_tx, e_busy, e_ready, e_gid);
         end
      end
      n_cmp++;
      if (run != CPB) begin
         n_bad++;
         $display("FAIL midreset_start_len got %0d exp %0d", run, CPB);
      end
   endtask

   task automatic test_drop_valid();
      int n_rdy = 0;
      int n_active = 0;
      do_reset();
      for (int c = 0; c < FL + 20; c++) begin
         step(c < FL ? 4'b0100 : 4'b0000, 28'($urandom));
         if (c > FL) begin
            if (req_ready !== 4'b0000) n_rdy++;
            if (serial_tx !== 1'b1 || busy !== 1'b0) n_active++;
         end
         n_cmp++;
         if ({serial_tx, busy, req_ready, grant_id} !== {e_tx, e_busy, e_ready, e_gid}) begin
            n_bad++;
            $display("FAIL drop c=%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", c, serial_tx, busy,
                     req_ready, grant_id, e_tx, e_busy, e_ready, e_gid);
         end
      end
      n_cmp++;
      if (n_rdy != 0 || n_active != 0) begin
         n_bad++;
         $display("FAIL drop_idle got ready_cycles=%0d active_cycles=%0d exp 0/0", n_rdy, n_active);
      end
   endtask

   task automatic test_random();
      logic [NR-1:0] v = '0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) v = 4'($urandom);
         step(v, 28'($urandom));
         n_cmp++;
         if ({serial_tx, busy, req_ready, grant_id} !== {e_tx, e_busy, e_ready, e_gid}) begin
            n_bad++;
            $display("FAIL random c=%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d", c, serial_tx, busy,
                     req_ready, grant_id, e_tx, e_busy, e_ready, e_gid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_data_change();
      test_reset_mid_frame();
      test_drop_valid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
